// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, one-deep in-flight imem read, DEPTH-entry {instr,pc} buffer to decode.
// Optional FETCH_STALL_CNT_EN adds stall_cnt_o, a wrapping count of cycles in which decode received nothing.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [31:0] pc_o
`ifdef FETCH_STALL_CNT_EN
  , output logic [31:0] stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          buf_q [DEPTH];
  entry_t          buf_d [DEPTH];
  entry_t          out_q, out_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inf_addr_q, inf_addr_d;
  logic            inflight_q, inflight_d;

  logic            pop, pop_eff, wr;
  logic [OW-1:0]   occ;
  logic            unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc_i[1:0];

  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign pop_eff = pop & ~redirect_i;
  assign wr      = inflight_q & ~redirect_i;

  // Occupancy the buffer would reach if the request issued now returns next cycle.
  assign occ = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);

  assign imem_req_o  = rst_i & ~redirect_i & (occ < OW'(DEPTH));
  assign imem_addr_o = pc_q;

  assign instr_o = out_q.instr;
  assign pc_o    = out_q.pc;
  assign op_o    = out_q.instr[31:26];

  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    inf_addr_d = inf_addr_q;
    out_d      = out_q;
    if (redirect_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      pc_d       = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (wr) begin
        buf_d[tail_q] = '{instr: imem_data_i, pc: inf_addr_q};
        tail_d        = tail_q + PW'(1);
      end
      if (pop_eff) head_d = head_q + PW'(1);
      count_d    = count_q + CW'(wr) - CW'(pop_eff);
      inflight_d = imem_req_o;
      if (imem_req_o) begin
        inf_addr_d = pc_q;
        pc_d       = pc_q + 32'd4;
      end
      // Output register tracks the new head; when the buffer drains it keeps the last one.
      if (count_d != '0) out_d = buf_d[head_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      out_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      inf_addr_q <= '0;
    end else begin
      buf_q      <= buf_d;
      out_q      <= out_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      inf_addr_q <= inf_addr_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(wr && (count_q == CW'(DEPTH)) && !pop_eff));

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A redirect discards the head, so that cycle counts as a stall even if decode was ready.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!(valid_o & ready_i) || redirect_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
